// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit sequencing fetch (T0..T2) and execute (T3..T7) steps.
// Ports: Clock/Clear (sync active-high reset), opcode (IR[31:27]), CON_FF (branch condition),
//   bus-drive strobes (PCout..InPortOut), load strobes (PCin..OutPortIn), IncPC/Read/RAMin,
//   register-file selects GRA/GRB/GRC with Rin/Rout, Run (0 only in HALT).
// Optional: CONTROL_SEQUENCER_STEP_EN adds input Step and a WAIT state between instructions.
module control_sequencer #(
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic [4:0] opcode,
  input  logic       CON_FF,
`ifdef CONTROL_SEQUENCER_STEP_EN
  input  logic       Step,
`endif
  output logic       PCout,
  output logic       ZLowout,
  output logic       ZHighout,
  output logic       MDRout,
  output logic       HIout,
  output logic       LOout,
  output logic       Cout,
  output logic       BAout,
  output logic       InPortOut,
  output logic       PCin,
  output logic       IRin,
  output logic       MARin,
  output logic       MDRin,
  output logic       Yin,
  output logic       ZLowIn,
  output logic       ZHighIn,
  output logic       HIin,
  output logic       LOin,
  output logic       CONin,
  output logic       OutPortIn,
  output logic       IncPC,
  output logic       Read,
  output logic       RAMin,
  output logic       GRA,
  output logic       GRB,
  output logic       GRC,
  output logic       Rin,
  output logic       Rout,
  output logic       Run
);
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef CONTROL_SEQUENCER_STEP_EN
    , S_WAIT
`endif
  } state_t;
  state_t state_q, state_d, t_last, done_st;
  logic alu, imm, unr, md, ldi, ld, st, br, jr, jal, inp, outp, mfhi, mflo, nop, hlt, ill;
  assign alu  = opcode inside {[5'd3:5'd11]};
  assign imm  = opcode inside {[5'd12:5'd14]};
  assign unr  = opcode inside {5'd17, 5'd18};
  assign md   = opcode inside {5'd15, 5'd16};
  assign ldi  = opcode == 5'd1;
  assign ld   = opcode == 5'd0;
  assign st   = opcode == 5'd2;
  assign br   = opcode == 5'd19;
  assign jr   = opcode == 5'd20;
  assign jal  = opcode == 5'd21;
  assign inp  = opcode == 5'd22;
  assign outp = opcode == 5'd23;
  assign mfhi = opcode == 5'd24;
  assign mflo = opcode == 5'd25;
  assign nop  = opcode == 5'd26;
  assign hlt  = opcode == 5'd27;
  assign ill  = opcode[4:2] == 3'b111;
  // Final execute step of the held opcode; single-step opcodes finish in T3.
  assign t_last = (ld || st) ? S_T7 : (md || br) ? S_T6 : (alu || imm || ldi) ? S_T5 :
                  (unr || jal) ? S_T4 : S_T3;
`ifdef CONTROL_SEQUENCER_STEP_EN
  assign done_st = S_WAIT;
`else
  assign done_st = S_T0;
`endif
  always_ff @(posedge Clock) begin
    if (Clear) state_q <= S_RESET;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = (hlt || (ill && !NOP_ON_ILLEGAL)) ? S_HALT : (nop || ill) ? done_st : S_T3;
      S_HALT:  state_d = S_HALT;
`ifdef CONTROL_SEQUENCER_STEP_EN
      S_WAIT:  state_d = Step ? S_T0 : S_WAIT;
`endif
      default: state_d = (state_q == t_last || state_q == S_T7) ? done_st : state_t'(state_q + 4'd1);
    endcase
  end
  always_comb begin
    {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, BAout, InPortOut} = '0;
    {PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, OutPortIn} = '0;
    {IncPC, Read, RAMin, GRA, GRB, GRC, Rin, Rout} = '0;
    Run = state_q != S_HALT;
    case (state_q)
      S_T0: {PCout, MARin, IncPC, ZLowIn} = '1;
      S_T1: {ZLowout, PCin, Read, MDRin} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3: begin
        if (alu || imm) {GRB, Rout, Yin} = '1;
        if (unr) {GRB, Rout, ZLowIn} = '1;
        if (md) {GRA, Rout, Yin} = '1;
        if (ldi || ld || st) {GRB, BAout, Yin} = '1;
        if (br) {GRA, Rout, CONin} = '1;
        if (jr) {GRA, Rout, PCin} = '1;
        if (jal) {PCout, GRB, Rin} = '1;
        if (inp) {InPortOut, GRA, Rin} = '1;
        if (outp) {GRA, Rout, OutPortIn} = '1;
        if (mfhi) {HIout, GRA, Rin} = '1;
        if (mflo) {LOout, GRA, Rin} = '1;
      end
      S_T4: begin
        if (alu) {GRC, Rout, ZLowIn} = '1;
        if (imm || ldi || ld || st) {Cout, ZLowIn} = '1;
        if (unr) {ZLowout, GRA, Rin} = '1;
        if (md) {GRB, Rout, ZLowIn, ZHighIn} = '1;
        if (br) {PCout, Yin} = '1;
        if (jal) {GRA, Rout, PCin} = '1;
      end
      S_T5: begin
        if (alu || imm || ldi) {ZLowout, GRA, Rin} = '1;
        if (md) {ZLowout, LOin} = '1;
        if (ld || st) {ZLowout, MARin} = '1;
        if (br) {Cout, ZLowIn} = '1;
      end
      S_T6: begin
        if (md) {ZHighout, HIin} = '1;
        if (ld) {Read, MDRin} = '1;
        if (st) {GRA, Rout, MDRin} = '1;
        // Only the taken branch loads PC; an untaken branch still spends this step.
        if (br && CON_FF) {ZLowout, PCin} = '1;
      end
      S_T7: begin
        if (ld) {MDRout, GRA, Rin} = '1;
        if (st) RAMin = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench comparing every cycle's strobe vector with expected sequences.
module tb_control_sequencer;
  logic Clock = 1'b0, Clear = 1'b1, CON_FF = 1'b0;
  logic [4:0] opcode = 5'd26;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, BAout, InPortOut;
  logic PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, OutPortIn;
  logic IncPC, Read, RAMin, GRA, GRB, GRC, Rin, Rout, Run;
  logic [28:0] obs, obs0;
  logic [27:0] s0;
  logic run0;
  int tests = 0, fails = 0;
  logic [28:0] sb[$];
  localparam logic [28:0] PCO = 29'd1 << 0, ZLO = 29'd1 << 1, ZHO = 29'd1 << 2, MDRO = 29'd1 << 3,
    HIO = 29'd1 << 4, LOO = 29'd1 << 5, CO = 29'd1 << 6, BAO = 29'd1 << 7, INO = 29'd1 << 8,
    PCI = 29'd1 << 9, IRI = 29'd1 << 10, MARI = 29'd1 << 11, MDRI = 29'd1 << 12, YI = 29'd1 << 13,
    ZLI = 29'd1 << 14, ZHI = 29'd1 << 15, HII = 29'd1 << 16, LOI = 29'd1 << 17, CONI = 29'd1 << 18,
    OPI = 29'd1 << 19, INC = 29'd1 << 20, RD = 29'd1 << 21, WR = 29'd1 << 22, GA = 29'd1 << 23,
    GB = 29'd1 << 24, GC = 29'd1 << 25, RI = 29'd1 << 26, RO = 29'd1 << 27, RUN = 29'd1 << 28;
  always #5 Clock = ~Clock;
  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .opcode(opcode), .CON_FF(CON_FF),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .BAout(BAout), .InPortOut(InPortOut), .PCin(PCin), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin),
    .LOin(LOin), .CONin(CONin), .OutPortIn(OutPortIn), .IncPC(IncPC), .Read(Read), .RAMin(RAMin),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .Run(Run)
  );
  control_sequencer #(.NOP_ON_ILLEGAL(1'b0)) dut0 (
    .Clock(Clock), .Clear(Clear), .opcode(opcode), .CON_FF(CON_FF),
    .PCout(s0[0]), .ZLowout(s0[1]), .ZHighout(s0[2]), .MDRout(s0[3]), .HIout(s0[4]),
    .LOout(s0[5]), .Cout(s0[6]), .BAout(s0[7]), .InPortOut(s0[8]), .PCin(s0[9]), .IRin(s0[10]),
    .MARin(s0[11]), .MDRin(s0[12]), .Yin(s0[13]), .ZLowIn(s0[14]), .ZHighIn(s0[15]), .HIin(s0[16]),
    .LOin(s0[17]), .CONin(s0[18]), .OutPortIn(s0[19]), .IncPC(s0[20]), .Read(s0[21]), .RAMin(s0[22]),
    .GRA(s0[23]), .GRB(s0[24]), .GRC(s0[25]), .Rin(s0[26]), .Rout(s0[27]), .Run(run0)
  );
  assign obs = {Run, Rout, Rin, GRC, GRB, GRA, RAMin, Read, IncPC, OutPortIn, CONin, LOin, HIin,
                ZHighIn, ZLowIn, Yin, MDRin, MARin, IRin, PCin, InPortOut, BAout, Cout, LOout,
                HIout, MDRout, ZHighout, ZLowout, PCout};
  assign obs0 = {run0, s0};
  task automatic step();
    @(posedge Clock);
    #1;
  endtask
  task automatic push_instr(input logic [4:0] op, input logic con);
    sb.push_back(RUN | PCO | MARI | INC | ZLI);
    sb.push_back(RUN | ZLO | PCI | RD | MDRI);
    sb.push_back(RUN | MDRO | IRI);
    case (op) inside
      [5'd3:5'd11]: begin
        sb.push_back(RUN | GB | RO | YI);
        sb.push_back(RUN | GC | RO | ZLI);
        sb.push_back(RUN | ZLO | GA | RI);
      end
      [5'd12:5'd14], 5'd1: begin
        sb.push_back(RUN | (op == 5'd1 ? (GB | BAO | YI) : (GB | RO | YI)));
        sb.push_back(RUN | CO | ZLI);
        sb.push_back(RUN | ZLO | GA | RI);
      end
      5'd17, 5'd18: begin
        sb.push_back(RUN | GB | RO | ZLI);
        sb.push_back(RUN | ZLO | GA | RI);
      end
      5'd15, 5'd16: begin
        sb.push_back(RUN | GA | RO | YI);
        sb.push_back(RUN | GB | RO | ZLI | ZHI);
        sb.push_back(RUN | ZLO | LOI);
        sb.push_back(RUN | ZHO | HII);
      end
      5'd0, 5'd2: begin
        sb.push_back(RUN | GB | BAO | YI);
        sb.push_back(RUN | CO | ZLI);
        sb.push_back(RUN | ZLO | MARI);
        sb.push_back(RUN | (op == 5'd0 ? (RD | MDRI) : (GA | RO | MDRI)));
        sb.push_back(RUN | (op == 5'd0 ? (MDRO | GA | RI) : WR));
      end
      5'd19: begin
        sb.push_back(RUN | GA | RO | CONI);
        sb.push_back(RUN | PCO | YI);
        sb.push_back(RUN | CO | ZLI);
        sb.push_back(RUN | (con ? (ZLO | PCI) : 29'd0));
      end
      5'd20: sb.push_back(RUN | GA | RO | PCI);
      5'd21: begin
        sb.push_back(RUN | PCO | GB | RI);
        sb.push_back(RUN | GA | RO | PCI);
      end
      5'd22: sb.push_back(RUN | INO | GA | RI);
      5'd23: sb.push_back(RUN | GA | RO | OPI);
      5'd24: sb.push_back(RUN | HIO | GA | RI);
      5'd25: sb.push_back(RUN | LOO | GA | RI);
      5'd27: for (int k = 0; k < 20; k++) sb.push_back(29'd0);
      default: ;
    endcase
  endtask
  task automatic run_instr(input string name, input logic [4:0] op, input logic con, input int stop_after);
    logic [28:0] e;
    int n;
    push_instr(op, con);
    n = (stop_after > 0 && stop_after < sb.size()) ? stop_after : sb.size();
    for (int i = 0; i < n; i++) begin
      step();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL %s step %0d: got %h want %h", name, i, obs, e);
      end
      if (i == 0) begin
        opcode = op;
        CON_FF = con;
      end
    end
    sb.delete();
  endtask
  task automatic test_reset();
    Clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (obs !== RUN) begin
        fails++;
        $display("FAIL reset cycle %0d: got %h want %h", i, obs, RUN);
      end
    end
    Clear = 1'b0;
  endtask
  task automatic test_add();
    run_instr("add", 5'd3, 1'b0, 0);
    run_instr("add_next", 5'd3, 1'b0, 0);
  endtask
  task automatic test_all_opcodes();
    logic [4:0] ops[26] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13,
                            5'd14, 5'd17, 5'd18, 5'd15, 5'd16, 5'd1, 5'd0, 5'd2, 5'd20, 5'd21,
                            5'd22, 5'd23, 5'd24, 5'd25, 5'd26};
    foreach (ops[i]) run_instr($sformatf("op%0d", ops[i]), ops[i], 1'b0, 0);
  endtask
  task automatic test_br();
    run_instr("br_taken", 5'd19, 1'b1, 0);
    run_instr("br_not_taken", 5'd19, 1'b0, 0);
    run_instr("after_br", 5'd26, 1'b0, 0);
  endtask
  task automatic test_store();
    run_instr("st", 5'd2, 1'b0, 0);
    run_instr("after_st", 5'd20, 1'b0, 0);
  endtask
  task automatic test_back_to_back();
    logic [4:0] op;
    for (int i = 0; i < 20; i++) begin
      op = 5'($urandom_range(0, 26));
      run_instr($sformatf("b2b%0d_op%0d", i, op), op, 1'($urandom_range(0, 1)), 0);
    end
  endtask
  task automatic test_clear_mid_mul();
    run_instr("mul_partial", 5'd15, 1'b0, 6);
    Clear = 1'b1;
    step();
    tests++;
    if (obs !== RUN) begin
      fails++;
      $display("FAIL clear_mid_mul: got %h want %h", obs, RUN);
    end
    Clear = 1'b0;
    run_instr("after_clear", 5'd16, 1'b0, 0);
  endtask
  task automatic test_illegal();
    run_instr("illegal_nop", 5'd30, 1'b0, 0);
    run_instr("after_illegal", 5'd26, 1'b0, 0);
    tests++;
    if (obs0 !== 29'd0) begin
      fails++;
      $display("FAIL illegal_halt: got %h want %h", obs0, 29'd0);
    end
  endtask
  task automatic test_halt();
    run_instr("halt", 5'd27, 1'b0, 0);
    Clear = 1'b1;
    step();
    tests++;
    if (obs !== RUN || obs0 !== RUN) begin
      fails++;
      $display("FAIL halt_clear: got %h/%h want %h", obs, obs0, RUN);
    end
    Clear = 1'b0;
    run_instr("after_halt", 5'd22, 1'b0, 0);
  endtask
  initial begin
    test_reset();
    test_add();
    test_all_opcodes();
    test_br();
    test_store();
    test_back_to_back();
    test_clear_mid_mul();
    test_illegal();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
